midi_rx: RTL and testbench
==========================

# midi_rx

Serial front end of the MIDI input path: oversamples the asynchronous 31.25 kbaud MIDI line and recovers 8N1 bytes. Drives an internal `shift_reg` (W=8, shift right, LSB first) with per-bit strobes, then presents each completed byte with a one-cycle valid pulse to the MIDI message parser downstream. Flags framing errors and rejects start-bit glitches.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 31250, line bit rate
- `clk`  input  1  system clock, all logic on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `rx`  input  1  raw MIDI line; asynchronous to `clk`; idle high
- `data`  output  8  last correctly framed byte
- `valid`  output  1  one-cycle pulse: `data` updated this cycle
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low
- `busy`  output  1  high in any state other than IDLE

## Operation
- DIV = CLK_HZ/BAUD (integer truncation); HALF = DIV/2. DIV < 4 is illegal (elaboration error). Bit-timer width $clog2(DIV); bit counter 3 bits.
- `rx` passes a 2-FF synchronizer; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: timer cleared, `shift_reg` clr asserted. `rx_s`==0 -> START, timer loaded with HALF-1.
- START: timer counts down. At 0: `rx_s`==0 -> DATA, timer = DIV-1, bit count = 0; `rx_s`==1 -> IDLE (glitch, no output).
- DATA: at timer 0, one-cycle `ce` to `shift_reg` with d=`rx_s`, timer reloads DIV-1, bit count +1. After the 8th sample (count 7) -> STOP.
- STOP: at timer 0, sample `rx_s`. 1 -> load `data` from `shift_reg` q, pulse `valid`, -> IDLE. 0 -> pulse `frame_err`, `data` unchanged, -> BREAK.
- BREAK: wait for `rx_s`==1 -> IDLE. Prevents a held-low line (break) from being read as a stream of 0x00 bytes.
- `valid` and `frame_err` are never high together.
- `data` holds its value between valid pulses; it never shows partial bytes.

## Timing
- Reset values: `data`=0x00, `valid`=0, `frame_err`=0, `busy`=0, state IDLE, synchronizer 1s, timers 0.
- Reset assertion mid-byte aborts immediately; no pulse is emitted. Reception resumes only on the next falling edge after release.
- Input latency: 2 cycles, `rx` to `rx_s`.
- Start sample: HALF cycles after IDLE sees `rx_s`==0. Data bit n is sampled HALF + (n+1)·DIV cycles after that. Stop bit is sampled HALF + 9·DIV cycles after that.
- `valid`/`frame_err` are registered and high in the cycle after the stop sample. `data` changes on the same edge that raises `valid`.
- Back-to-back bytes: IDLE is reached half a bit before the stop bit ends. A start edge immediately following the stop bit is caught with no lost cycles.
- `busy` rises the cycle after the start edge is seen in IDLE. It falls in the cycle `valid` is high, or when BREAK exits.

## Structure
- Shared package `midi_pkg`:
  - state enum `rx_state_t`
  - `MIDI_BAUD` = 31250
  - function `clk_div(clk_hz, baud)`
- Sub-module: existing `shift_reg` with W=8 and dir tied to 1.
  - `clr` comes from IDLE, so it is held clear between bytes.
  - `ce`/`d` come from the DATA sampling strobe.
- FSM, timers and synchronizer live in `midi_rx`.

## Test plan
Sim parameters: CLK_HZ=16, BAUD=1, so DIV=16 and HALF=8.
- Reset release with line idle -> all outputs 0. No pulses for 500 cycles.
- Send 0x90 (start, bits LSB-first 0,0,0,0,1,0,0,1, stop) -> one `valid` pulse, `data`=0x90, `frame_err` never high.
- Bytes 0x3C then 0x7F sent with no idle gap -> two `valid` pulses, 160 cycles apart, `data` 0x3C then 0x7F.
- Line low for 4 cycles then high -> `busy` pulses briefly, returns to IDLE, no `valid`/`frame_err`, `data` unchanged.
- 0x55 sent with stop bit low, line held low 100 cycles, then high -> one `frame_err` pulse, no `valid`, `data` retains prior 0x7F. No further pulses while held low. Next 0x01 is received correctly.
- `rst_n` pulsed low during bit 4 of 0xAA -> no pulse, `data`=0x00. A following 0x12 is received correctly.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI receive path: state encoding, line rate and
// the clock-divider helper used to size the bit timer.
package midi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int MIDI_BAUD = 31250;

  function automatic int clk_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/shift_reg.sv
// Generic serial-in shift register with synchronous clear and clock enable.
// dir=1 shifts right (new bit enters at the MSB), dir=0 shifts left.
module shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ce,
  input  logic         dir,
  input  logic         d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ce) begin
      if (dir) q <= {d, q[W-1:1]};
      else     q <= {q[W-2:0], d};
    end
  end

endmodule

// File: rtl/midi_rx.sv
// MIDI serial receiver: synchronizes the raw line, times 8N1 frames from the
// middle of the start bit, and emits each byte with a one-cycle valid pulse.
module midi_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = MIDI_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV  = clk_div(CLK_HZ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int TW   = $clog2(DIV);

  if (DIV < 4) begin : g_div_check
    $error("midi_rx: CLK_HZ/BAUD must be at least 4");
  end

  rx_state_t       state;
  logic [TW-1:0]   timer;
  logic [2:0]      cnt;
  logic            rx_m;
  logic            rx_s;
  logic            sr_clr;
  logic            sr_ce;
  logic [7:0]      sr_q;

  // Two-flop synchronizer; idle-high reset avoids a false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign sr_clr = (state == IDLE);
  assign sr_ce  = (state == DATA) && (timer == '0);

  shift_reg #(.W(8)) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sr_clr),
    .ce    (sr_ce),
    .dir   (1'b1),
    .d     (rx_s),
    .q     (sr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      cnt       <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (!rx_s) begin
            state <= START;
            timer <= TW'(HALF - 1);
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == '0) begin
            if (!rx_s) begin
              state <= DATA;
              timer <= TW'(DIV - 1);
              cnt   <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DATA: begin
          if (timer == '0) begin
            timer <= TW'(DIV - 1);
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) state <= STOP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        STOP: begin
          if (timer == '0) begin
            if (rx_s) begin
              data  <= sr_q;
              valid <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        BREAK: begin
          // Held-low line: wait for release rather than framing more 0x00s.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_rx.sv
// Scoreboard bench for midi_rx at DIV=16: stimulus queues expected events,
// an independent monitor checks every valid/frame_err pulse against them.
module tb_midi_rx;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    logic       is_err;
    logic [7:0] byte_v;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  longint cyc = 0;
  longint valid_cyc[$];
  logic busy_seen;

  midi_rx #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per output pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_seen = 1'b1;
      if (valid && frame_err) check("valid_and_frame_err", 32'd1, 32'd0);
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_kind_is_err", {31'd0, frame_err}, {31'd0, e.is_err});
          check("pulse_data", {24'd0, data}, {24'd0, e.byte_v});
          if (valid) valid_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic bits(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    bits(1'b0, 16);
    for (int i = 0; i < 8; i++) bits(b[i], 16);
    bits(stop_v, 16);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.byte_v = b;
    exp_q.push_back(e);
  endtask

  initial begin
    int nv;
    rx = 1'b1;
    rst_n = 1'b0;
    busy_seen = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // Idle line: any pulse here is reported by the monitor.
    repeat (500) @(posedge clk);
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_data", {24'd0, data}, 32'd0);

    @(posedge clk);
    expect_byte(8'h90);
    send_byte(8'h90, 1'b1);
    bits(1'b1, 20);
    check("byte_90_consumed", exp_q.size(), 32'd0);

    // Back-to-back with no idle gap.
    nv = valid_cyc.size();
    expect_byte(8'h3C);
    expect_byte(8'h7F);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h7F, 1'b1);
    bits(1'b1, 20);
    check("b2b_consumed", exp_q.size(), 32'd0);
    if (valid_cyc.size() == nv + 2)
      check("b2b_spacing", 32'(valid_cyc[nv+1] - valid_cyc[nv]), 32'd160);
    else
      check("b2b_pulse_count", valid_cyc.size() - nv, 32'd2);

    // Start-bit glitch.
    busy_seen = 1'b0;
    bits(1'b0, 4);
    bits(1'b1, 40);
    @(negedge clk);
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_after", {31'd0, busy}, 32'd0);
    check("glitch_data_kept", {24'd0, data}, 32'h7F);

    // Framing error, then break held low.
    @(posedge clk);
    begin
      exp_t e;
      e.is_err = 1'b1;
      e.byte_v = 8'h7F;
      exp_q.push_back(e);
    end
    send_byte(8'h55, 1'b0);
    bits(1'b0, 100);
    @(negedge clk);
    check("break_busy_held", {31'd0, busy}, 32'd1);
    check("break_consumed", exp_q.size(), 32'd0);
    @(posedge clk);
    bits(1'b1, 20);
    @(negedge clk);
    check("break_exit_busy", {31'd0, busy}, 32'd0);
    check("break_data_kept", {24'd0, data}, 32'h7F);
    @(posedge clk);
    expect_byte(8'h01);
    send_byte(8'h01, 1'b1);
    bits(1'b1, 20);
    check("after_break_consumed", exp_q.size(), 32'd0);

    // Reset asserted in the middle of bit 4 of 0xAA.
    bits(1'b0, 16);
    for (int i = 0; i < 4; i++) bits(i[0], 16);
    bits(1'b0, 8);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("midreset_data", {24'd0, data}, 32'd0);
    check("midreset_busy_after", {31'd0, busy}, 32'd0);
    @(posedge clk);
    expect_byte(8'h12);
    send_byte(8'h12, 1'b1);
    bits(1'b1, 40);
    check("final_consumed", exp_q.size(), 32'd0);
    check("final_data", {24'd0, data}, 32'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
